// File: rtl/prio_irq_ctrl.sv
// Priority interrupt controller: eight active-low request lines, fixed priority
// (line 7 highest), per-line mask, and a three-state issue/acknowledge/service
// sequence toward the CPU. A new interrupt is only issued from IDLE, so a line
// that becomes pending later cannot preempt the one already issued.
//
// CPU handshake: irq acts as "valid" and ack as "ready". While irq is high, vec
// is frozen. The transfer completes on the rising edge where irq=1 and ack=1.
// On that edge pending[vec] is cleared and the controller enters SERVICE.
// Later, an eoi pulse in SERVICE frees the controller. An ack outside REQ and
// an eoi outside SERVICE have no effect.
//
// o_dbg_state exposes the FSM state as 0=IDLE, 1=REQ, 2=SERVICE.
module prio_irq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_n,
  input  logic       ei_n,
  input  logic       mask_we,
  input  logic [7:0] mask_wdata,
  input  logic       ack,
  input  logic       eoi,
  output logic       irq,
  output logic [2:0] vec,
  output logic       busy,
  output logic       gs_n,
  output logic       eo_n,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_req_q;
  logic [7:0] r_pending;
  logic [7:0] r_mask;
  logic [2:0] r_vec;

  logic [7:0] w_fall;
  logic [7:0] w_active;
  logic [7:0] w_clr;
  logic [7:0] w_pending_nxt;
  logic [2:0] w_winner;
  logic [2:0] w_vec_nxt;
  logic       w_any_active;
  logic       w_ack_take;

  // A falling edge on a line: it was high last cycle and is low now.
  assign w_fall       = r_req_q & ~req_n;
  assign w_active     = r_pending & ~r_mask;
  assign w_any_active = |w_active;

  // Highest-index active line. The loop runs upward, so the last hit is the winner.
  always_comb begin
    w_winner = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_active[i]) w_winner = i[2:0];
    end
  end

  // Next state and latched vector. Ack takes precedence over withdrawal in REQ.
  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_ack_take  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!ei_n && w_any_active) begin
          w_state_nxt = S_REQ;
          w_vec_nxt   = w_winner;
        end
      end
      S_REQ: begin
        if (ack) begin
          w_ack_take  = 1'b1;
          w_state_nxt = S_SERVICE;
        end else if (ei_n) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (eoi) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Clear the acknowledged line. A same-cycle new edge still re-sets it below.
  always_comb begin
    w_clr = 8'h00;
    if (w_ack_take) w_clr[r_vec] = 1'b1;
  end

  assign w_pending_nxt = (r_pending & ~w_clr) | w_fall;

  // Request sampling, pending, mask, vector and state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_req_q   <= 8'hFF;
      r_pending <= 8'h00;
      r_mask    <= 8'h00;
      r_vec     <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_req_q   <= req_n;
      r_pending <= w_pending_nxt;
      if (mask_we) r_mask <= mask_wdata;
      r_vec     <= w_vec_nxt;
    end
  end

  // Outputs are decoded from registered state. gs_n and eo_n also gate on ei_n.
  assign irq         = (r_state == S_REQ);
  assign busy        = (r_state == S_SERVICE);
  assign vec         = r_vec;
  assign gs_n        = ~(~ei_n & w_any_active);
  assign eo_n        = ~(~ei_n & (r_state == S_IDLE) & ~w_any_active);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_prio_irq_ctrl.sv
// Bench for prio_irq_ctrl. The reference model is cycle-based. It tracks
// per-line pending/mask bits in arrays and a phase (idle/issued/in-service).
// After each rising edge, the model applies the controller's rules. Outputs
// are compared on the following falling edge.
module tb_prio_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_n = 8'hFF;
  logic       ei_n = 1'b0;
  logic       mask_we = 1'b0;
  logic [7:0] mask_wdata = 8'h00;
  logic       ack = 1'b0;
  logic       eoi = 1'b0;
  logic       irq;
  logic [2:0] vec;
  logic       busy;
  logic       gs_n;
  logic       eo_n;
  logic [1:0] o_dbg_state;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  prio_irq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_n(req_n), .ei_n(ei_n),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .ack(ack), .eoi(eoi),
    .irq(irq), .vec(vec), .busy(busy), .gs_n(gs_n), .eo_n(eo_n),
    .o_dbg_state(o_dbg_state)
  );

  // reference model
  localparam int PH_IDLE    = 0;
  localparam int PH_ISSUED  = 1;
  localparam int PH_SERVICE = 2;

  bit m_pend[8];
  bit m_mask[8];
  bit m_prev[8];
  int m_phase;
  int m_vec;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_pend[i] = 1'b0;
      m_mask[i] = 1'b0;
      m_prev[i] = 1'b1;
    end
    m_phase = PH_IDLE;
    m_vec   = 0;
  endtask

  // One rising edge, evaluated with the inputs held across that edge.
  task automatic model_edge();
    int best;
    if (!rst_n) begin
      model_reset();
      return;
    end
    best = -1;
    for (int i = 0; i < 8; i++) if (m_pend[i] && !m_mask[i]) best = i;
    if (m_phase == PH_IDLE) begin
      if (!ei_n && best >= 0) begin
        m_phase = PH_ISSUED;
        m_vec   = best;
      end
    end else if (m_phase == PH_ISSUED) begin
      if (ack) begin
        m_phase       = PH_SERVICE;
        m_pend[m_vec] = 1'b0;
      end else if (ei_n) begin
        m_phase = PH_IDLE;
      end
    end else begin
      if (eoi) m_phase = PH_IDLE;
    end
    // Edges are applied after the ack clear so a coincident new edge wins.
    for (int i = 0; i < 8; i++) begin
      if (m_prev[i] && !req_n[i]) m_pend[i] = 1'b1;
      m_prev[i] = req_n[i];
    end
    if (mask_we) for (int i = 0; i < 8; i++) m_mask[i] = mask_wdata[i];
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    bit any_act;
    any_act = 1'b0;
    for (int i = 0; i < 8; i++) if (m_pend[i] && !m_mask[i]) any_act = 1'b1;
    chk({tag, ".irq"},   {7'd0, irq},  {7'd0, m_phase == PH_ISSUED});
    chk({tag, ".busy"},  {7'd0, busy}, {7'd0, m_phase == PH_SERVICE});
    chk({tag, ".vec"},   {5'd0, vec},  m_vec[7:0]);
    chk({tag, ".gs_n"},  {7'd0, gs_n}, {7'd0, !(!ei_n && any_act)});
    chk({tag, ".eo_n"},  {7'd0, eo_n}, {7'd0, !(!ei_n && m_phase == PH_IDLE && !any_act)});
    chk({tag, ".state"}, {6'd0, o_dbg_state}, m_phase[7:0]);
  endtask

  // driver
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic pulse_ack(input string tag);
    ack = 1'b1;
    step(tag);
    ack = 1'b0;
  endtask

  task automatic pulse_eoi(input string tag);
    eoi = 1'b1;
    step(tag);
    eoi = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_model("reset");
    chk("reset.eo_n_eq_ei_n", {7'd0, eo_n}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("idle");

    // Single line 2: two edges to irq, then ack and eoi.
    req_n = 8'b1111_1011;
    step("l2.e1");
    chk("l2.e1.irq_low", {7'd0, irq}, 8'd0);
    step("l2.e2");
    chk("l2.irq", {7'd0, irq}, 8'd1);
    chk("l2.vec", {5'd0, vec}, 8'd2);
    req_n = 8'hFF;
    pulse_ack("l2.ack");
    chk("l2.busy", {7'd0, busy}, 8'd1);
    chk("l2.irq_after_ack", {7'd0, irq}, 8'd0);
    pulse_eoi("l2.eoi");
    chk("l2.busy_after_eoi", {7'd0, busy}, 8'd0);

    // Lines 1 and 6 together: 6 first, then 1 one cycle after returning to IDLE.
    req_n = 8'b1011_1101;
    step("l16.e1");
    step("l16.e2");
    chk("l16.vec6", {5'd0, vec}, 8'd6);
    req_n = 8'hFF;
    pulse_ack("l16.ack6");
    pulse_eoi("l16.eoi6");
    chk("l16.gap_irq", {7'd0, irq}, 8'd0);
    step("l16.issue1");
    chk("l16.vec1", {5'd0, vec}, 8'd1);
    pulse_ack("l16.ack1");
    pulse_eoi("l16.eoi1");

    // No preemption: line 7 falls while line 2 is issued.
    req_n = 8'b1111_1011;
    step("np.e1");
    step("np.e2");
    req_n = 8'b0111_1111;
    step("np.l7");
    chk("np.vec_frozen", {5'd0, vec}, 8'd2);
    req_n = 8'hFF;
    pulse_ack("np.ack2");
    pulse_eoi("np.eoi2");
    step("np.issue7");
    chk("np.vec7", {5'd0, vec}, 8'd7);
    pulse_ack("np.ack7");
    pulse_eoi("np.eoi7");

    // Masking holds line 7 back without losing it.
    mask_we = 1'b1; mask_wdata = 8'h80;
    step("mk.w80");
    mask_we = 1'b0;
    req_n = 8'b0111_1111;
    step("mk.e1");
    step("mk.e2");
    chk("mk.irq_masked", {7'd0, irq}, 8'd0);
    chk("mk.gs_n_masked", {7'd0, gs_n}, 8'd1);
    mask_we = 1'b1; mask_wdata = 8'h00;
    step("mk.w00");
    mask_we = 1'b0;
    step("mk.issue");
    chk("mk.irq", {7'd0, irq}, 8'd1);
    chk("mk.vec7", {5'd0, vec}, 8'd7);
    req_n = 8'hFF;
    pulse_ack("mk.ack");
    pulse_eoi("mk.eoi");

    // Withdrawal by ei_n, then reissue with the same vector.
    req_n = 8'b1110_1111;
    step("wd.e1");
    step("wd.e2");
    ei_n = 1'b1;
    step("wd.withdraw");
    chk("wd.irq", {7'd0, irq}, 8'd0);
    chk("wd.state", {6'd0, o_dbg_state}, 8'd0);
    chk("wd.eo_n", {7'd0, eo_n}, 8'd1);
    ei_n = 1'b0;
    step("wd.reissue");
    chk("wd.vec4", {5'd0, vec}, 8'd4);
    chk("wd.irq_again", {7'd0, irq}, 8'd1);
    req_n = 8'hFF;
    pulse_ack("wd.ack");
    pulse_eoi("wd.eoi");

    // New edge on the acknowledged line in the ack cycle keeps it pending.
    req_n = 8'b1111_0111;
    step("sw.e1");
    step("sw.e2");
    req_n = 8'hFF;
    step("sw.rise");
    req_n = 8'b1111_0111;
    pulse_ack("sw.ack_edge");
    req_n = 8'hFF;
    pulse_eoi("sw.eoi");
    step("sw.reissue");
    chk("sw.vec3", {5'd0, vec}, 8'd3);
    chk("sw.irq", {7'd0, irq}, 8'd1);
    pulse_ack("sw.ack2");
    pulse_eoi("sw.eoi2");

    // Reset during SERVICE with lines 3 and 5 pending.
    req_n = 8'b1101_0111;
    step("rs.e1");
    step("rs.e2");
    pulse_ack("rs.ack");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("rs.async");
    chk("rs.busy", {7'd0, busy}, 8'd0);
    chk("rs.gs_n", {7'd0, gs_n}, 8'd1);
    req_n = 8'hFF;
    step("rs.hold");
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step("rs.after");
      chk("rs.irq_quiet", {7'd0, irq}, 8'd0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 5) == 0) req_n[b] = ~req_n[b];
      ei_n       = ($urandom_range(0, 7) == 0);
      mask_we    = ($urandom_range(0, 15) == 0);
      mask_wdata = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      ack        = ($urandom_range(0, 2) == 0);
      eoi        = ($urandom_range(0, 3) == 0);
      step("rnd");
    end
    ack = 1'b0; eoi = 1'b0; mask_we = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
